reg_file_dumper: RTL
====================

// Module: reg_file_dumper
// PURPOSE
//  Debug reader for the MCU register file. On a start pulse it walks every register index,
//  reads each word through a spare asynchronous read port of the register file, and streams
//  the words out as bytes, MSB first, over a valid/ready byte interface (UART TX / debug FIFO).
//  It gives register visibility on hardware without the ILA.
// PARAMETERS
//  NUM_REGS   32   registers dumped, indices 0..NUM_REGS-1
//  ADDR_W     5    register address width
//  DATA_W     32   register width; must be a multiple of 8
// PORTS
//  CLK        in   1       clock; all state updates on posedge
//  RESET      in   1       asynchronous, active-high reset
//  start      in   1       one-cycle request to begin a dump; ignored while busy
//  abort      in   1       synchronous cancel of a dump in progress
//  busy       out  1       high from the cycle after an accepted start until return to IDLE
//  done       out  1       one-cycle pulse after the final byte handshake
//  rf_addr    out  ADDR_W  register file read address (spare read port)
//  rf_data    in   DATA_W  combinational read data for rf_addr
//  tx_data    out  8       byte to transmit
//  tx_valid   out  1       tx_data is valid
//  tx_ready   in   1       sink accepts the byte when tx_valid && tx_ready at posedge
// BEHAVIOUR
//  Reset values: busy=0, done=0, tx_valid=0, tx_data=0, rf_addr=0, idx=0, state=IDLE.
//  RESET acts immediately, with no clock edge needed; a dump in flight is discarded.
//  FSM: IDLE -> ADDR -> SEND -> (ADDR | CSUM | DONE) -> IDLE.
//   IDLE: rf_addr=0. On start=1: idx<=0, go to ADDR.
//   ADDR: rf_addr=idx for one full cycle. At posedge, word_q<=rf_data, byte_cnt<=0, go to SEND.
//         The register file writes on negedge, so the capture sees writes from the previous half-cycle.
//   SEND: tx_valid=1, tx_data=word_q[DATA_W-1 -: 8].
//         On each handshake: word_q shifts left by 8 and byte_cnt increments.
//         tx_data is held stable while tx_valid && !tx_ready.
//         After the last byte of a word: if idx==NUM_REGS-1, go to CSUM (when enabled) or DONE;
//         otherwise idx<=idx+1 and go to ADDR.
//   DONE: done=1 for one cycle, busy=0 next cycle, go to IDLE.
//  Latency: tx_valid first rises 2 cycles after the start edge.
//   Word-to-word gap is 1 cycle (the ADDR state).
//  Stream: NUM_REGS*DATA_W/8 bytes; register k occupies bytes k*4..k*4+3, big-endian.
//  Coherence: each word is a snapshot taken at its ADDR capture. There is no cross-word atomicity.
//  abort=1 in any non-IDLE state: IDLE next cycle, tx_valid drops even if a byte is pending,
//   no done pulse. abort in IDLE has no effect.
//  If start and abort are asserted in the same cycle in IDLE, start wins.
//  Register 0 is dumped as the register file returns it (0).
//  idx does not wrap; it saturates at NUM_REGS-1.
// CONFIGURATION
//  RF_DUMP_CHECKSUM_EN defined:
//   - keep a running XOR of every byte handshaken, cleared on start;
//   - after the last data byte, state CSUM sends the XOR as one extra byte with the same
//     valid/ready rules, then goes to DONE;
//   - stream length is NUM_REGS*DATA_W/8+1.
//  RF_DUMP_CHECKSUM_EN undefined: no CSUM state and no XOR register; stream length is NUM_REGS*DATA_W/8.
// STRUCTURE
//  Shared package mcu_dbg_pkg: FSM state encoding (IDLE/ADDR/SEND/CSUM/DONE) and
//   localparam BYTES_PER_WORD = DATA_W/8.
//  One sub-module: rf_byte_serializer.
//   - loads a DATA_W word and emits bytes MSB first over valid/ready;
//   - reports last_byte;
//   - the dumper FSM owns indexing, abort and checksum.
// TESTING
//  1. reg[k]=32'hA500_0000|k, tx_ready=1 always, start:
//     - 128 bytes: A5,00,00,k per k;
//     - first tx_valid 2 cycles after start;
//     - done pulses once, 1 cycle after byte 128.
//  2. Same preload, tx_ready random 50%:
//     - identical byte stream;
//     - tx_data never changes while tx_valid && !tx_ready.
//  3. start pulsed again mid-dump: ignored, stream unchanged.
//     abort after byte 50:
//     - tx_valid=0 and busy=0 next cycle, no done;
//     - a new start restarts at reg 0.
//  4. RESET raised between clock edges mid-SEND:
//     - busy, tx_valid, tx_data, rf_addr are 0 before the next posedge;
//     - after release the FSM is IDLE.
//  5. With RF_DUMP_CHECKSUM_EN, all regs 0 except reg[3]=32'h12345678:
//     - 129 bytes, last byte 8'h08.
//     Without the macro: exactly 128 bytes.
//  6. A write to reg 5 on the negedge before reg 5's ADDR capture:
//     - the new value appears in bytes 20..23.
//     The same write after the capture: the old value appears.

Source files
------------

// File: rtl/mcu_dbg_pkg.sv
// Shared definitions for the MCU debug readers: dumper FSM state encoding and word geometry.
// The RF_DUMP_CHECKSUM_EN build option only adds use of ST_CSUM; the encoding is fixed.
package mcu_dbg_pkg;

    localparam int DATA_W_DEF     = 32;
    localparam int BYTES_PER_WORD = DATA_W_DEF / 8;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_ADDR = 3'd1;
    localparam logic [2:0] ST_SEND = 3'd2;
    localparam logic [2:0] ST_CSUM = 3'd3;
    localparam logic [2:0] ST_DONE = 3'd4;

    // Byte counter width for a word of data_w bits; never below one bit.
    function automatic int byte_cnt_w(input int data_w);
        return (data_w / 8 > 1) ? $clog2(data_w / 8) : 1;
    endfunction

endpackage

// File: rtl/reg_file_dumper_if.sv
// Register-file spare read port plus valid/ready byte stream used by reg_file_dumper.
// master = the dumper, slave = the register file / byte sink side.
interface reg_file_dumper_if #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0] rf_addr;
    logic [DATA_W-1:0] rf_data;
    logic [7:0]        tx_data;
    logic              tx_valid;
    logic              tx_ready;

    modport master (
        output rf_addr, tx_data, tx_valid,
        input  rf_data, tx_ready
    );

    modport slave (
        input  rf_addr, tx_data, tx_valid,
        output rf_data, tx_ready
    );
endinterface

// File: rtl/rf_byte_serializer.sv
// Loads one register word and hands it out MSB-first, one byte per valid/ready handshake.
// Indexing, abort and checksum live in the dumper FSM, not here.
module rf_byte_serializer
    import mcu_dbg_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              load,
    input  logic [DATA_W-1:0] word,
    input  logic              en,
    input  logic              ready,
    output logic              valid,
    output logic [7:0]        data,
    output logic              fire,
    output logic              last_byte
);
    localparam int BPW   = DATA_W / 8;
    localparam int CNT_W = byte_cnt_w(DATA_W);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BPW - 1);

    logic [DATA_W-1:0] word_q;
    logic [CNT_W-1:0]  byte_cnt;

    assign valid     = en;
    assign fire      = en & ready;
    assign data      = word_q[DATA_W-1 -: 8];
    assign last_byte = (byte_cnt == LAST_CNT);

    // Shifting only on a handshake keeps data stable while the sink stalls.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            word_q   <= '0;
            byte_cnt <= '0;
        end else if (load) begin
            word_q   <= word;
            byte_cnt <= '0;
        end else if (fire) begin
            word_q   <= word_q << 8;
            byte_cnt <= byte_cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/reg_file_dumper.sv
// Walks every register index on start and streams each word big-endian over a byte valid/ready link.
// Define RF_DUMP_CHECKSUM_EN to append a trailing XOR-of-all-bytes checksum byte.
module reg_file_dumper
    import mcu_dbg_pkg::*;
#(
    parameter int NUM_REGS = 32,
    parameter int ADDR_W   = 5,
    parameter int DATA_W   = DATA_W_DEF
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              start,
    input  logic              abort,
    output logic              busy,
    output logic              done,
    reg_file_dumper_if.master bus
);
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

    logic [2:0]        state;
    logic [2:0]        state_nxt;
    logic [ADDR_W-1:0] idx;
    logic              ser_valid;
    logic              ser_fire;
    logic              ser_last;
    logic [7:0]        ser_data;
    logic              last_word;
    logic              word_end;

    assign last_word = (idx == LAST_IDX);
    assign word_end  = ser_fire & ser_last;

    rf_byte_serializer #(.DATA_W(DATA_W)) u_ser (
        .CLK       (CLK),
        .RESET     (RESET),
        .load      (state == ST_ADDR),
        .word      (bus.rf_data),
        .en        (state == ST_SEND),
        .ready     (bus.tx_ready),
        .valid     (ser_valid),
        .data      (ser_data),
        .fire      (ser_fire),
        .last_byte (ser_last)
    );

`ifdef RF_DUMP_CHECKSUM_EN
    logic [7:0] csum;
    logic       csum_fire;

    assign csum_fire = (state == ST_CSUM) & bus.tx_ready;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            csum <= '0;
        end else if (state == ST_IDLE && start) begin
            csum <= '0;
        end else if (ser_fire) begin
            csum <= csum ^ ser_data;
        end
    end

    assign bus.tx_valid = ser_valid | (state == ST_CSUM);
    assign bus.tx_data  = (state == ST_SEND) ? ser_data :
                          (state == ST_CSUM) ? csum     : 8'h00;
`else
    assign bus.tx_valid = ser_valid;
    assign bus.tx_data  = (state == ST_SEND) ? ser_data : 8'h00;
`endif

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (start) state_nxt = ST_ADDR;
            ST_ADDR: state_nxt = abort ? ST_IDLE : ST_SEND;
            ST_SEND: begin
                if (abort) begin
                    state_nxt = ST_IDLE;
                end else if (word_end) begin
`ifdef RF_DUMP_CHECKSUM_EN
                    state_nxt = last_word ? ST_CSUM : ST_ADDR;
`else
                    state_nxt = last_word ? ST_DONE : ST_ADDR;
`endif
                end
            end
`ifdef RF_DUMP_CHECKSUM_EN
            ST_CSUM: begin
                if (abort)          state_nxt = ST_IDLE;
                else if (csum_fire) state_nxt = ST_DONE;
            end
`endif
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state <= ST_IDLE;
            idx   <= '0;
        end else begin
            state <= state_nxt;
            if (state == ST_IDLE && start) begin
                idx <= '0;
            end else if (state == ST_SEND && !abort && word_end && !last_word) begin
                idx <= idx + ADDR_W'(1);
            end
        end
    end

    // idx holds its last value after a dump, so the port is forced to 0 in IDLE.
    assign bus.rf_addr = (state == ST_IDLE) ? '0 : idx;
    assign busy        = (state != ST_IDLE);
    assign done        = (state == ST_DONE);

endmodule
